// File: rtl/periph_select_pkg.sv
// periph_select_pkg
// Shared definitions for the peripheral chip-select controller:
//   - state_e      : controller FSM states
//   - ERR_*        : err_code encodings reported on the err_code output
//   - *_DEF        : default values for the N_CH / ADDR_W / TIMEOUT parameters
package periph_select_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WAIT  = 2'b01,
        ST_DONE  = 2'b10,
        ST_ERROR = 2'b11
    } state_e;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_ADDR = 2'b01;
    localparam logic [1:0] ERR_TMO  = 2'b10;

    localparam int N_CH_DEF    = 8;
    localparam int ADDR_W_DEF  = 5;
    localparam int TIMEOUT_DEF = 255;

endpackage

// File: rtl/periph_select_decode.sv
// periph_select_decode
// Combinational channel decoder. Code a in 1..N_CH selects channel a-1;
// code 0 and every code above N_CH decode to all-zero with valid low.
// Ports:
//   code   in  [ADDR_W-1:0]  channel code
//   onehot out [N_CH-1:0]    one-hot channel select (all-zero when invalid)
//   valid  out               code maps to a channel
module periph_select_decode
    import periph_select_pkg::*;
#(
    parameter int N_CH   = N_CH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic [ADDR_W-1:0] code,
    output logic [N_CH-1:0]   onehot,
    output logic              valid
);

    // Compare the code against every channel's code; at most one can match,
    // so the result is one-hot by construction.
    always_comb begin
        onehot = {N_CH{1'b0}};
        for (int i = 0; i < N_CH; i++) begin
            if (code == ADDR_W'(i + 1)) begin
                onehot[i] = 1'b1;
            end else begin
                onehot[i] = 1'b0;
            end
        end
        valid = |onehot;
    end

endmodule

// File: rtl/periph_select_ctrl.sv
// periph_select_ctrl
// Peripheral chip-select controller. A request in IDLE with a valid channel
// code raises that channel's chip_select (registered, one cycle later) and
// waits for the same channel's acknowledge; completion gives a one-cycle done
// pulse, an invalid code gives a one-cycle err pulse.
// Optional feature macro: PERIPH_SELECT_TIMEOUT_EN -- adds a WAIT-state
// cycle counter that aborts to ERROR (err_code 10) after TIMEOUT cycles.
// Ports:
//   clk            in   rising-edge clock
//   rst            in   asynchronous active-high reset
//   req            in   transaction request (sampled in IDLE only)
//   buffer_address in   [ADDR_W-1:0] channel code, sampled with req
//   periph_ack     in   [N_CH-1:0] per-channel completion acknowledge
//   chip_select    out  [N_CH-1:0] registered one-hot channel select
//   busy           out  high whenever not IDLE
//   done           out  one-cycle successful-completion pulse
//   err            out  one-cycle error pulse
//   err_code       out  [1:0] cause of the most recent err
module periph_select_ctrl
    import periph_select_pkg::*;
#(
    parameter int N_CH    = N_CH_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [ADDR_W-1:0] buffer_address,
    input  logic [N_CH-1:0]   periph_ack,
    output logic [N_CH-1:0]   chip_select,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code
);

    // Elaboration-time parameter range guards.
    if ((N_CH < 2) || (N_CH > 32)) begin : g_bad_nch
        $error("periph_select_ctrl: N_CH must be in 2..32");
    end
    if ((2 ** ADDR_W) <= N_CH) begin : g_bad_addr_w
        $error("periph_select_ctrl: 2**ADDR_W must exceed N_CH");
    end
    if ((TIMEOUT < 1) || (TIMEOUT > 65535)) begin : g_bad_timeout
        $error("periph_select_ctrl: TIMEOUT must be in 1..65535");
    end

    state_e            state_r;
    state_e            next_state_s;
    logic [N_CH-1:0]   dec_onehot_s;
    logic              dec_valid_s;
    logic              ack_hit_s;
    logic              tmo_hit_s;

    logic [N_CH-1:0]   cs_r;
    logic              busy_r;
    logic              done_r;
    logic              err_r;
    logic [1:0]        err_code_r;

    logic [N_CH-1:0]   cs_nxt_s;
    logic              busy_nxt_s;
    logic              done_nxt_s;
    logic              err_nxt_s;
    logic [1:0]        err_code_nxt_s;

    periph_select_decode #(
        .N_CH   (N_CH),
        .ADDR_W (ADDR_W)
    ) u_decode (
        .code   (buffer_address),
        .onehot (dec_onehot_s),
        .valid  (dec_valid_s)
    );

    // The held chip_select doubles as the latched channel, so masking the
    // acks with it ignores every other channel's acknowledge.
    assign ack_hit_s = (state_r == ST_WAIT) && (|(periph_ack & cs_r));

`ifdef PERIPH_SELECT_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] tmo_cnt_r;

    // WAIT cycle counter: held at zero outside WAIT so it starts from zero on entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_r <= {CNT_W{1'b0}};
        end else if (state_r != ST_WAIT) begin
            tmo_cnt_r <= {CNT_W{1'b0}};
        end else begin
            tmo_cnt_r <= tmo_cnt_r + CNT_W'(1);
        end
    end

    // Counter value TIMEOUT-1 marks the last of TIMEOUT WAIT cycles.
    assign tmo_hit_s = (state_r == ST_WAIT) && (tmo_cnt_r == CNT_W'(TIMEOUT - 1));
`else
    assign tmo_hit_s = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; ack is tested before timeout so it wins a tie.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req) begin
                    if (dec_valid_s) begin
                        next_state_s = ST_WAIT;
                    end else begin
                        next_state_s = ST_ERROR;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (ack_hit_s) begin
                    next_state_s = ST_DONE;
                end else if (tmo_hit_s) begin
                    next_state_s = ST_ERROR;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_DONE:  next_state_s = ST_IDLE;
            ST_ERROR: next_state_s = ST_IDLE;
            default:  next_state_s = ST_IDLE;
        endcase
    end

    // Output logic: derives next-cycle output values from the upcoming state
    // so the registered outputs line up with the state register.
    always_comb begin
        cs_nxt_s       = {N_CH{1'b0}};
        err_code_nxt_s = err_code_r;
        busy_nxt_s     = (next_state_s != ST_IDLE);
        done_nxt_s     = (next_state_s == ST_DONE);
        err_nxt_s      = (next_state_s == ST_ERROR);
        case (next_state_s)
            ST_WAIT: begin
                // Load the decoded channel on entry, then hold it unchanged.
                cs_nxt_s = (state_r == ST_IDLE) ? dec_onehot_s : cs_r;
            end
            ST_ERROR: begin
                // Errors raised from IDLE are address errors; from WAIT, timeouts.
                err_code_nxt_s = (state_r == ST_IDLE) ? ERR_ADDR : ERR_TMO;
            end
            ST_IDLE: cs_nxt_s = {N_CH{1'b0}};
            ST_DONE: cs_nxt_s = {N_CH{1'b0}};
            default: cs_nxt_s = {N_CH{1'b0}};
        endcase
    end

    // Output registers; reset drops chip_select and all pulses immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_r       <= {N_CH{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            err_code_r <= ERR_NONE;
        end else begin
            cs_r       <= cs_nxt_s;
            busy_r     <= busy_nxt_s;
            done_r     <= done_nxt_s;
            err_r      <= err_nxt_s;
            err_code_r <= err_code_nxt_s;
        end
    end

    assign chip_select = cs_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign err         = err_r;
    assign err_code    = err_code_r;

endmodule

// File: tb/tb_periph_select_ctrl.sv
// tb_periph_select_ctrl
// Directed bench for periph_select_ctrl: an 8-channel instance (TIMEOUT=16)
// for transaction, error, reset and timeout scenarios, and a 16-channel
// instance for a full code sweep.
module tb_periph_select_ctrl;

    logic        clk;
    logic        rst;

    logic        req;
    logic [4:0]  addr;
    logic [7:0]  ack;
    logic [7:0]  cs;
    logic        busy;
    logic        done;
    logic        err;
    logic [1:0]  err_code;

    logic        req16;
    logic [4:0]  addr16;
    logic [15:0] ack16;
    logic [15:0] cs16;
    logic        busy16;
    logic        done16;
    logic        err16;
    logic [1:0]  err_code16;

    logic [15:0] exp16;

    int vectors;
    int miscompares;

    periph_select_ctrl #(
        .N_CH    (8),
        .ADDR_W  (5),
        .TIMEOUT (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req            (req),
        .buffer_address (addr),
        .periph_ack     (ack),
        .chip_select    (cs),
        .busy           (busy),
        .done           (done),
        .err            (err),
        .err_code       (err_code)
    );

    periph_select_ctrl #(
        .N_CH    (16),
        .ADDR_W  (5),
        .TIMEOUT (16)
    ) dut16 (
        .clk            (clk),
        .rst            (rst),
        .req            (req16),
        .buffer_address (addr16),
        .periph_ack     (ack16),
        .chip_select    (cs16),
        .busy           (busy16),
        .done           (done16),
        .err            (err16),
        .err_code       (err_code16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst    = 1'b1;
        req    = 1'b0;
        addr   = 5'd0;
        ack    = 8'h00;
        req16  = 1'b0;
        addr16 = 5'd0;
        ack16  = 16'h0000;

        // Reset state
        @(negedge clk);
        check("rst_cs",       32'(cs),       32'h0);
        check("rst_busy",     32'(busy),     32'h0);
        check("rst_done",     32'(done),     32'h0);
        check("rst_err",      32'(err),      32'h0);
        check("rst_err_code", 32'(err_code), 32'h0);

        // Request on the first edge after reset release: addr 3 -> channel 2
        rst  = 1'b0;
        req  = 1'b1;
        addr = 5'd3;
        @(negedge clk);
        check("t1_cs",   32'(cs),   32'h04);
        check("t1_busy", 32'(busy), 32'h1);
        req = 1'b0;
        @(negedge clk);
        check("t1_cs_hold2", 32'(cs), 32'h04);
        @(negedge clk);
        check("t1_cs_hold3", 32'(cs), 32'h04);
        @(negedge clk);
        check("t1_cs_hold4", 32'(cs),   32'h04);
        check("t1_no_done",  32'(done), 32'h0);
        ack = 8'h04;
        @(negedge clk);
        check("t1_done",      32'(done), 32'h1);
        check("t1_done_cs",   32'(cs),   32'h00);
        check("t1_done_busy", 32'(busy), 32'h1);
        ack = 8'h00;
        @(negedge clk);
        check("t1_done_pulse", 32'(done), 32'h0);
        check("t1_idle_busy",  32'(busy), 32'h0);

        // Invalid code 0
        req  = 1'b1;
        addr = 5'd0;
        @(negedge clk);
        check("a0_err",      32'(err),      32'h1);
        check("a0_err_code", 32'(err_code), 32'h1);
        check("a0_cs",       32'(cs),       32'h00);
        req = 1'b0;
        @(negedge clk);
        check("a0_err_pulse", 32'(err),      32'h0);
        check("a0_code_held", 32'(err_code), 32'h1);
        check("a0_busy",      32'(busy),     32'h0);

        // Invalid code 9 (just above N_CH)
        req  = 1'b1;
        addr = 5'd9;
        @(negedge clk);
        check("a9_err",      32'(err),      32'h1);
        check("a9_err_code", 32'(err_code), 32'h1);
        check("a9_cs",       32'(cs),       32'h00);
        req = 1'b0;
        @(negedge clk);
        check("a9_err_pulse", 32'(err), 32'h0);

        // Foreign acks and a new request during WAIT are ignored
        req  = 1'b1;
        addr = 5'd2;
        @(negedge clk);
        check("t4_cs", 32'(cs), 32'h02);
        ack  = 8'h81;
        addr = 5'd6;
        @(negedge clk);
        check("t4_cs_hold", 32'(cs),   32'h02);
        check("t4_no_done", 32'(done), 32'h0);
        @(negedge clk);
        check("t4_cs_hold2", 32'(cs),   32'h02);
        check("t4_busy",     32'(busy), 32'h1);
        ack = 8'h02;
        req = 1'b0;
        @(negedge clk);
        check("t4_done",      32'(done),     32'h1);
        check("t4_code_held", 32'(err_code), 32'h1);
        ack = 8'h00;
        @(negedge clk);

        // Asynchronous reset in the middle of WAIT
        req  = 1'b1;
        addr = 5'd7;
        @(negedge clk);
        check("t5_cs", 32'(cs), 32'h40);
        req = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("t5_async_cs",   32'(cs),       32'h00);
        check("t5_async_busy", 32'(busy),     32'h0);
        check("t5_async_code", 32'(err_code), 32'h0);
        @(negedge clk);
        check("t5_no_done", 32'(done), 32'h0);
        check("t5_no_err",  32'(err),  32'h0);
        rst  = 1'b0;
        req  = 1'b1;
        addr = 5'd1;
        @(negedge clk);
        check("t5_first_req_cs", 32'(cs), 32'h01);
        req = 1'b0;
        ack = 8'h01;
        @(negedge clk);
        check("t5_done", 32'(done), 32'h1);
        ack = 8'h00;
        @(negedge clk);

`ifdef PERIPH_SELECT_TIMEOUT_EN
        // Timeout after 16 WAIT cycles with no ack
        req  = 1'b1;
        addr = 5'd5;
        @(negedge clk);
        req = 1'b0;
        check("tmo_cs_c1", 32'(cs), 32'h10);
        for (int k = 2; k <= 16; k++) begin
            @(negedge clk);
        end
        check("tmo_cs_c16",  32'(cs),  32'h10);
        check("tmo_err_c16", 32'(err), 32'h0);
        @(negedge clk);
        check("tmo_err",      32'(err),      32'h1);
        check("tmo_err_code", 32'(err_code), 32'h2);
        check("tmo_cs",       32'(cs),       32'h00);
        @(negedge clk);
        check("tmo_idle", 32'(busy), 32'h0);

        // Ack on WAIT cycle 16 beats the timeout
        req  = 1'b1;
        addr = 5'd5;
        @(negedge clk);
        req = 1'b0;
        for (int k = 2; k <= 16; k++) begin
            @(negedge clk);
        end
        ack = 8'h10;
        @(negedge clk);
        check("tie_done",      32'(done),     32'h1);
        check("tie_no_err",    32'(err),      32'h0);
        check("tie_code_held", 32'(err_code), 32'h2);
        ack = 8'h00;
        @(negedge clk);
`else
        // Without the timeout, WAIT persists until the ack arrives
        req  = 1'b1;
        addr = 5'd5;
        @(negedge clk);
        req = 1'b0;
        repeat (40) @(negedge clk);
        check("notmo_cs",   32'(cs),       32'h10);
        check("notmo_busy", 32'(busy),     32'h1);
        check("notmo_err",  32'(err),      32'h0);
        check("notmo_code", 32'(err_code), 32'h0);
        ack = 8'h10;
        @(negedge clk);
        check("notmo_done", 32'(done), 32'h1);
        ack = 8'h00;
        @(negedge clk);
`endif

        // 16-channel sweep of every 5-bit code
        for (int c = 0; c < 32; c++) begin
            exp16  = ((c >= 1) && (c <= 16)) ? (16'd1 << (c - 1)) : 16'd0;
            req16  = 1'b1;
            addr16 = 5'(c);
            @(negedge clk);
            req16 = 1'b0;
            check("sweep_onehot0", 32'($onehot0(cs16)), 32'h1);
            if (exp16 != 16'd0) begin
                check("sweep_cs", 32'(cs16), 32'(exp16));
                ack16 = exp16;
                @(negedge clk);
                ack16 = 16'h0000;
                check("sweep_done",    32'(done16), 32'h1);
                check("sweep_done_cs", 32'(cs16),   32'h0);
                @(negedge clk);
            end else begin
                check("sweep_err",      32'(err16),      32'h1);
                check("sweep_err_code", 32'(err_code16), 32'h1);
                check("sweep_err_cs",   32'(cs16),       32'h0);
                @(negedge clk);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
